// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the memory port arbiter.
package rv32i_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} arb_owner_e;
  localparam logic [2:0] FUNCT3_LW = 3'b010;
  localparam int REQ_AW = 16;
  localparam int REQ_DW = 32;
  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/starve_prio_pick.sv
// starve_prio_pick: LS-priority grant with a counter that forces IF after STARVE_LIMIT LS wins.
module starve_prio_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic aresetn,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  logic force_if;
  always_comb begin
    force_if = if_valid && starve_cnt == CW'(STARVE_LIMIT);
    grant_ls = aresetn && ls_valid && !force_if;
    grant_if = aresetn && if_valid && !grant_ls;
  end
  // an LS grant only happens below the limit, so the increment saturates by construction
  always_ff @(posedge clk)
    if (!aresetn || !if_valid || grant_if) starve_cnt <= '0;
    else starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and LS with a fixed 1-cycle response pipe.
// Optional MEM_ARB_PERF_EN adds perf_if_stall / perf_ls_grants counters.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int MEM_WIDTH    = 16,
  parameter int MLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [MEM_WIDTH-1:0] if_req_addr,
  input  logic                 if_flush,
  output logic                 if_rsp_valid,
  output logic [MLEN-1:0]      if_rsp_data,
  output logic                 if_rsp_err,
  input  logic                 ls_req_valid,
  output logic                 ls_req_ready,
  input  logic                 ls_req_we,
  input  logic [2:0]           ls_req_funct3,
  input  logic [MEM_WIDTH-1:0] ls_req_addr,
  input  logic [MLEN-1:0]      ls_req_wdata,
  output logic                 ls_rsp_valid,
  output logic [MLEN-1:0]      ls_rsp_data,
  output logic [1:0]           ls_rsp_err,
  output logic [2:0]           mem_funct3,
  output logic [MEM_WIDTH-1:0] mem_rd_addr,
  output logic [MEM_WIDTH-1:0] mem_wr_addr,
  output logic [MLEN-1:0]      mem_wr_data,
  output logic                 mem_wr_en,
  input  logic [MLEN-1:0]      mem_rd_data,
  input  logic [1:0]           mem_error
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_if_stall,
  output logic [31:0]          perf_ls_grants
`endif
);
  logic grant_if, grant_ls;
  arb_owner_e owner;
  logic owner_we;
  logic [2:0] last_funct3;
  logic [MEM_WIDTH-1:0] last_addr;
  logic [MLEN-1:0] last_wdata;

  starve_prio_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk      (clk),
    .aresetn  (aresetn),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // idle cycles keep the last issued address/funct3/data on the bus
  always_comb begin
    if_req_ready = grant_if;
    ls_req_ready = grant_ls;
    mem_funct3   = grant_ls ? ls_req_funct3 : grant_if ? FUNCT3_LW : last_funct3;
    mem_rd_addr  = grant_ls ? ls_req_addr : grant_if ? if_req_addr : last_addr;
    mem_wr_addr  = mem_rd_addr;
    mem_wr_data  = grant_ls ? ls_req_wdata : last_wdata;
    mem_wr_en    = grant_ls && ls_req_we;
    if_rsp_valid = owner == OWN_IF && !if_flush;
    if_rsp_data  = if_rsp_valid ? mem_rd_data : '0;
    if_rsp_err   = if_rsp_valid && mem_error[0];
    ls_rsp_valid = owner == OWN_LS;
    ls_rsp_data  = ls_rsp_valid && !owner_we ? mem_rd_data : '0;
    ls_rsp_err   = ls_rsp_valid ? mem_error : 2'b00;
  end

  always_ff @(posedge clk)
    if (!aresetn) begin
      owner       <= OWN_NONE;
      owner_we    <= 1'b0;
      last_funct3 <= '0;
      last_addr   <= '0;
      last_wdata  <= '0;
    end else begin
      owner       <= grant_ls ? OWN_LS : grant_if ? OWN_IF : OWN_NONE;
      owner_we    <= grant_ls && ls_req_we;
      last_funct3 <= mem_funct3;
      last_addr   <= mem_rd_addr;
      last_wdata  <= mem_wr_data;
    end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk)
    if (!aresetn) begin
      perf_if_stall  <= '0;
      perf_ls_grants <= '0;
    end else begin
      perf_if_stall  <= perf_if_stall + 32'(if_req_valid && !if_req_ready);
      perf_ls_grants <= perf_ls_grants + 32'(grant_ls);
    end
`endif
endmodule
